hs32_fetch: RTL and testbench

Instruction fetch stage for the HS32 core. It reads 32-bit instruction words from the memory bus at a word-aligned program counter and holds them in a small prefetch FIFO. From that FIFO it presents instructions to the decode stage over a valid/ready handshake. A flush input from execute redirects fetch to a new PC and discards all buffered and in-flight words.

---
 rtl/hs32_fetch_if.sv | 24 ++
 rtl/hs32_fetch.sv | 144 ++++++++++++++
 tb/tb_hs32_fetch.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hs32_fetch_if.sv
// Fetch-stage bus bundle: decode handshake, memory read port and redirect.
// The master side is the fetch unit; the slave side is the surrounding core/memory.
interface hs32_fetch_if;
  logic [31:0] instd;
  logic [31:0] instpc;
  logic        ackd;
  logic        reqd;
  logic [31:0] addr;
  logic        reqm;
  logic        ackm;
  logic [31:0] datm;
  logic        flush;
  logic [31:0] newpc;

  modport master (
    output instd, instpc, ackd, addr, reqm,
    input  reqd, ackm, datm, flush, newpc
  );

  modport slave (
    input  instd, instpc, ackd, addr, reqm,
    output reqd, ackm, datm, flush, newpc
  );
endinterface

// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: single-outstanding memory reader feeding a small
// {pc, inst} prefetch FIFO, with flush/redirect that drops in-flight data.
module hs32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  hs32_fetch_if.master bus
);
  localparam int            AW         = $clog2(DEPTH);
  localparam int            CW         = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [31:0]   RESET_PC_W = RESET_PC & ~32'd3;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          reqm_q, reqm_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic        ackd;
  logic        push;
  logic        pop;
  logic        clear;
  logic [31:0] newpc_w;

  assign ackd    = (count_q != '0);
  assign pop     = bus.reqd && ackd;
  assign push    = (state_q == WAIT) && bus.ackm && !bus.flush;
  assign newpc_w = bus.newpc & ~32'd3;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    reqm_d     = reqm_q;
    clear      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          fetch_pc_d = newpc_w;
          clear      = 1'b1;
        end else if ((count_q - CW'(pop)) < DEPTH_C) begin
          reqm_d  = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          clear      = 1'b1;
          fetch_pc_d = newpc_w;
          if (bus.ackm) begin
            reqm_d  = 1'b0;
            state_d = IDLE;
          end else begin
            // The stale request must still complete before a new one can issue.
            state_d = DROP;
          end
        end else if (bus.ackm) begin
          fetch_pc_d = addr_q + 32'd4;
          if ((count_q + CW'(1) - CW'(pop)) < DEPTH_C) begin
            addr_d = addr_q + 32'd4;
          end else begin
            reqm_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (bus.flush) begin
          fetch_pc_d = newpc_w;
          clear      = 1'b1;
        end
        if (bus.ackm) begin
          reqm_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    if (clear) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC_W;
      addr_q     <= RESET_PC_W;
      reqm_q     <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      reqm_q     <= reqm_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero before the first fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= addr_q;
      inst_mem_q[wr_ptr_q] <= bus.datm;
    end
  end

  assign bus.instd  = inst_mem_q[rd_ptr_q];
  assign bus.instpc = pc_mem_q[rd_ptr_q];
  assign bus.ackd   = ackd;
  assign bus.addr   = addr_q;
  assign bus.reqm   = reqm_q;

  a_fifo_bounds: assert property (@(posedge clk) disable iff (!reset)
    (count_q <= DEPTH_C) && !(push && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_hs32_fetch.sv
// Directed bench for hs32_fetch: per-cycle vector table from reset, then
// hand-written flush, flush-with-ack, PC wrap and mid-request reset sequences.
module tb_hs32_fetch;
  localparam logic [31:0] XMASK = 32'hA5A5_A5A5;

  logic clk;
  logic reset;
  logic mem_auto;
  logic ackm_man;
  int   n_tests;
  int   n_fail;

  hs32_fetch_if bus ();

  hs32_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: returns addr ^ XMASK; zero-wait when mem_auto, else manual ack.
  assign bus.ackm = mem_auto ? bus.reqm : ackm_man;
  assign bus.datm = bus.addr ^ XMASK;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        reqd;
    logic        exp_ackd;
    logic [31:0] exp_pc;
    logic        exp_reqm;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " reqm"},   32'(bus.reqm), 32'd0);
    chk({tag, " addr"},   bus.addr,      32'h0000_0100);
    chk({tag, " ackd"},   32'(bus.ackd), 32'd0);
    chk({tag, " instd"},  bus.instd,     32'd0);
    chk({tag, " instpc"}, bus.instpc,    32'd0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, " ackd"},   32'(bus.ackd), 32'd1);
    chk({tag, " instpc"}, bus.instpc,    pc);
    chk({tag, " instd"},  bus.instd,     pc ^ XMASK);
  endtask

  task automatic chk_req(input string tag, input logic rq, input logic [31:0] a);
    chk({tag, " reqm"}, 32'(bus.reqm), 32'(rq));
    chk({tag, " addr"}, bus.addr,      a);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b0;
    mem_auto = 1'b1;
    ackm_man = 1'b0;
    bus.reqd  = 1'b0;
    bus.flush = 1'b0;
    bus.newpc = 32'd0;

    // reqd, ackd, head pc, reqm, addr -- outputs after each posedge
    vecs[0] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h100};
    vecs[1] = '{1'b0, 1'b1, 32'h100, 1'b1, 32'h104};
    vecs[2] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h104};
    vecs[3] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h104};
    vecs[4] = '{1'b1, 1'b1, 32'h104, 1'b1, 32'h108};
    vecs[5] = '{1'b0, 1'b1, 32'h104, 1'b0, 32'h108};
    vecs[6] = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h10C};
    vecs[7] = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h110};
    vecs[8] = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h114};
    vecs[9] = '{1'b1, 1'b1, 32'h114, 1'b1, 32'h118};

    step();
    step();
    chk_reset("reset");
    #3 reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      bus.reqd = vecs[i].reqd;
      step();
      chk($sformatf("vec%0d ackd", i), 32'(bus.ackd), 32'(vecs[i].exp_ackd));
      chk($sformatf("vec%0d reqm", i), 32'(bus.reqm), 32'(vecs[i].exp_reqm));
      chk($sformatf("vec%0d addr", i), bus.addr,      vecs[i].exp_addr);
      if (vecs[i].exp_ackd) begin
        chk($sformatf("vec%0d instpc", i), bus.instpc, vecs[i].exp_pc);
        chk($sformatf("vec%0d instd", i),  bus.instd,  vecs[i].exp_pc ^ XMASK);
      end
    end

    // Flush while 0x118 is outstanding, stale ack arrives 3 cycles later
    mem_auto = 1'b0;
    ackm_man = 1'b0;
    bus.reqd = 1'b0;
    step();
    chk_req("hold", 1'b1, 32'h118);
    chk_head("hold", 32'h114);
    bus.flush = 1'b1;
    bus.newpc = 32'h0000_2003;
    step();
    bus.flush = 1'b0;
    chk("flush ackd", 32'(bus.ackd), 32'd0);
    chk_req("drop0", 1'b1, 32'h118);
    step();
    step();
    chk_req("drop2", 1'b1, 32'h118);
    ackm_man = 1'b1;
    step();
    ackm_man = 1'b0;
    chk("stale reqm", 32'(bus.reqm), 32'd0);
    chk("stale ackd", 32'(bus.ackd), 32'd0);
    step();
    chk_req("redirect", 1'b1, 32'h2000);
    mem_auto = 1'b1;
    bus.reqd = 1'b1;
    step();
    chk_head("first2000", 32'h2000);
    chk("first2000 addr", bus.addr, 32'h2004);

    // Flush coinciding with ackm (and a pop)
    bus.flush = 1'b1;
    bus.newpc = 32'h0000_3000;
    step();
    bus.flush = 1'b0;
    chk_req("flushack", 1'b0, 32'h2004);
    chk("flushack ackd", 32'(bus.ackd), 32'd0);
    step();
    chk_req("req3000", 1'b1, 32'h3000);
    chk("req3000 ackd", 32'(bus.ackd), 32'd0);
    step();
    chk_head("got3000", 32'h3000);

    // PC wrap through 2^32
    bus.flush = 1'b1;
    bus.newpc = 32'hFFFF_FFF8;
    step();
    bus.flush = 1'b0;
    chk("wrap flush reqm", 32'(bus.reqm), 32'd0);
    step();
    chk_req("wrap req", 1'b1, 32'hFFFF_FFF8);
    step();
    chk_head("wrap0", 32'hFFFF_FFF8);
    chk("wrap0 addr", bus.addr, 32'hFFFF_FFFC);
    step();
    chk_head("wrap1", 32'hFFFF_FFFC);
    chk("wrap1 addr", bus.addr, 32'h0000_0000);
    step();
    chk_head("wrap2", 32'h0000_0000);
    chk("wrap2 addr", bus.addr, 32'h0000_0004);

    // Asynchronous reset in the middle of a request, ack during reset ignored
    mem_auto = 1'b0;
    ackm_man = 1'($urandom_range(0, 1));
    #2 reset = 1'b0;
    #1;
    chk_reset("async");
    ackm_man = 1'b1;
    step();
    step();
    chk_reset("inreset");
    ackm_man = 1'b0;
    #3 reset = 1'b1;
    mem_auto = 1'b1;
    step();
    chk_req("restart", 1'b1, 32'h100);
    chk("restart ackd", 32'(bus.ackd), 32'd0);
    step();
    chk_head("restart", 32'h100);
    chk("restart addr", bus.addr, 32'h104);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
